// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the block RAM port seen by dmem_arbiter.
// slave: arbiter side. master: requester/RAM side (testbench or SoC glue).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    // Port A (core MEM stage)
    logic              a_req;
    logic              a_we;
    logic [31:0]       a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    // Port B (loader / IO master)
    logic              b_req;
    logic              b_we;
    logic [31:0]       b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    // Block RAM port
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port block RAM between port A (core)
// and port B (loader/IO). One access per cycle, read data returned to the
// owner one cycle after the grant. A has priority; with MEM_ARB_FAIR_EN
// defined, B is forced through after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
`ifdef MEM_ARB_FAIR_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    owner_e r_rd_owner;
    owner_e w_rd_owner_nxt;
    logic   w_sel_a;
    logic   w_sel_b;
    logic   w_force_b;

    // Byte-offset and wrap bits of the requester addresses are intentionally dropped
    logic   w_unused;
    assign w_unused = ^{bus.a_addr[31:ADDR_W+2], bus.a_addr[1:0],
                        bus.b_addr[31:ADDR_W+2], bus.b_addr[1:0]};

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve_cnt;

    // Count consecutive cycles B waits while requesting; saturate at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (bus.b_req && !w_sel_b) begin
            if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign w_force_b = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign w_force_b = 1'b0;
`endif

    // Read-return owner register: remembers who gets ram_dout next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Same-cycle arbitration, RAM port mux and next read owner
    always_comb begin
        w_sel_a        = 1'b0;
        w_sel_b        = 1'b0;
        w_rd_owner_nxt = OWN_NONE;
        bus.ram_en     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_di     = '0;

        if (!rst) begin
            w_sel_b      = bus.b_req && (!bus.a_req || w_force_b);
            w_sel_a      = bus.a_req && !w_sel_b;
            bus.ram_en   = w_sel_a || w_sel_b;
            bus.ram_addr = bus.a_addr[ADDR_W+1:2];
            bus.ram_di   = bus.a_wdata;
            if (w_sel_b) begin
                bus.ram_we   = bus.b_we;
                bus.ram_addr = bus.b_addr[ADDR_W+1:2];
                bus.ram_di   = bus.b_wdata;
                if (!bus.b_we) begin
                    w_rd_owner_nxt = OWN_B;
                end
            end else if (w_sel_a) begin
                bus.ram_we = bus.a_we;
                if (!bus.a_we) begin
                    w_rd_owner_nxt = OWN_A;
                end
            end
        end
    end

    assign bus.a_gnt    = w_sel_a;
    assign bus.b_gnt    = w_sel_b;
    assign bus.a_rvalid = (r_rd_owner == OWN_A);
    assign bus.b_rvalid = (r_rd_owner == OWN_B);
    assign bus.a_rdata  = bus.a_rvalid ? bus.ram_dout : '0;
    assign bus.b_rdata  = bus.b_rvalid ? bus.ram_dout : '0;
endmodule
